// File: rtl/fifo_scoreboard_if.sv
// Snoop bundle between a FIFO bench and fifo_scoreboard: observed handshakes in, status out.
// The master side is the bench; the slave side is the scoreboard.
interface fifo_scoreboard_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 32,
    parameter int OCC_W = 5
);
    logic             i_cg;
    logic [WIDTH-1:0] i_wdata;
    logic             i_wvalid;
    logic             i_wready;
    logic [WIDTH-1:0] i_rdata;
    logic             i_rvalid;
    logic             i_rready;
    logic [CNT_W-1:0] o_nPushed;
    logic [CNT_W-1:0] o_nPopped;
    logic [CNT_W-1:0] o_nErrors;
    logic [OCC_W-1:0] o_occupancy;
    logic             o_fail;
    logic [2:0]       o_errCode;
    logic [WIDTH-1:0] o_errExpected;
    logic [WIDTH-1:0] o_errActual;

    modport master (
        output i_cg, i_wdata, i_wvalid, i_wready, i_rdata, i_rvalid, i_rready,
        input  o_nPushed, o_nPopped, o_nErrors, o_occupancy, o_fail,
               o_errCode, o_errExpected, o_errActual
    );

    modport slave (
        input  i_cg, i_wdata, i_wvalid, i_wready, i_rdata, i_rvalid, i_rready,
        output o_nPushed, o_nPopped, o_nErrors, o_occupancy, o_fail,
               o_errCode, o_errExpected, o_errActual
    );
endinterface

// File: rtl/fifo_scoreboard.sv
// Passive in-order FIFO checker: reference queue of pushed words, compare on pop,
// read-side stall stability check, first-failure capture and saturating counters.
module fifo_scoreboard #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter bit BYPASS = 1'b0,
    parameter int CNT_W  = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    fifo_scoreboard_if.slave sb
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_MISMATCH  = 3'd1;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW  = 3'd3;
    localparam logic [2:0] ERR_VDROP     = 3'd4;
    localparam logic [2:0] ERR_DCHANGE   = 3'd5;

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FAIL = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr_r, rptr_r, occ_r;
    logic [CNT_W-1:0] n_pushed_r, n_popped_r, n_errors_r;
    logic             stall_r;
    logic [WIDTH-1:0] stall_data_r;
    state_t           state_r;
    logic             fail_r;
    logic [2:0]       err_code_r;
    logic [WIDTH-1:0] err_expected_r, err_actual_r;

    logic             push_s, pop_s, empty_s, full_s;
    logic             pop_ok_s, bypass_s, wr_en_s;
    logic             mismatch_s, underflow_s, overflow_s, vdrop_s, dchange_s, any_err_s;
    logic [WIDTH-1:0] expected_s;
    logic [PTR_W-1:0] wptr_nx_s, rptr_nx_s;
    logic [2:0]       code_s;

    // Handshake decode, reference-queue compare and error classification
    always_comb begin
        push_s      = sb.i_cg & sb.i_wvalid & sb.i_wready;
        pop_s       = sb.i_cg & sb.i_rvalid & sb.i_rready;
        empty_s     = (wptr_r == rptr_r);
        full_s      = (wptr_r[PTR_W-1] != rptr_r[PTR_W-1]) &&
                      (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        pop_ok_s    = 1'b0;
        bypass_s    = 1'b0;
        underflow_s = 1'b0;
        overflow_s  = 1'b0;
        wr_en_s     = 1'b0;
        vdrop_s     = 1'b0;
        dchange_s   = 1'b0;
        expected_s  = {WIDTH{1'b0}};

        // Expected word comes from pre-push contents; bypass only when the model is empty
        if (pop_s) begin
            if (!empty_s) begin
                expected_s = mem[rptr_r[AW-1:0]];
                pop_ok_s   = 1'b1;
            end else if (BYPASS && push_s) begin
                expected_s = sb.i_wdata;
                bypass_s   = 1'b1;
            end else begin
                underflow_s = 1'b1;
            end
        end else begin
            pop_ok_s = 1'b0;
        end
        mismatch_s = (pop_ok_s | bypass_s) && (expected_s != sb.i_rdata);

        // A same-cycle pop frees the slot, so full+push+pop is legal
        if (push_s && !bypass_s) begin
            if (full_s && !pop_ok_s) begin
                overflow_s = 1'b1;
            end else begin
                wr_en_s = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end

        if (sb.i_cg && stall_r) begin
            if (!sb.i_rvalid) begin
                vdrop_s = 1'b1;
            end else if (sb.i_rdata != stall_data_r) begin
                dchange_s = 1'b1;
            end else begin
                dchange_s = 1'b0;
            end
        end else begin
            vdrop_s = 1'b0;
        end

        wptr_nx_s = wr_en_s  ? (wptr_r + PTR_ONE) : wptr_r;
        rptr_nx_s = pop_ok_s ? (rptr_r + PTR_ONE) : rptr_r;
        any_err_s = mismatch_s | underflow_s | overflow_s | vdrop_s | dchange_s;

        if (mismatch_s) begin
            code_s = ERR_MISMATCH;
        end else if (underflow_s) begin
            code_s = ERR_UNDERFLOW;
        end else if (overflow_s) begin
            code_s = ERR_OVERFLOW;
        end else if (vdrop_s) begin
            code_s = ERR_VDROP;
        end else if (dchange_s) begin
            code_s = ERR_DCHANGE;
        end else begin
            code_s = ERR_NONE;
        end
    end

    // Reference queue storage; contents are meaningless outside wptr/rptr so no reset
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem[wptr_r[AW-1:0]] <= sb.i_wdata;
        end
    end

    // Pointers, occupancy, counters and stall tracker
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wptr_r       <= {PTR_W{1'b0}};
            rptr_r       <= {PTR_W{1'b0}};
            occ_r        <= {PTR_W{1'b0}};
            n_pushed_r   <= {CNT_W{1'b0}};
            n_popped_r   <= {CNT_W{1'b0}};
            n_errors_r   <= {CNT_W{1'b0}};
            stall_r      <= 1'b0;
            stall_data_r <= {WIDTH{1'b0}};
        end else begin
            wptr_r <= wptr_nx_s;
            rptr_r <= rptr_nx_s;
            occ_r  <= wptr_nx_s - rptr_nx_s;
            if (wr_en_s || bypass_s) begin
                n_pushed_r <= sat_inc(n_pushed_r);
            end
            if (pop_ok_s || bypass_s) begin
                n_popped_r <= sat_inc(n_popped_r);
            end
            if (any_err_s) begin
                n_errors_r <= sat_inc(n_errors_r);
            end
            // Gated cycles leave the tracker untouched
            if (sb.i_cg) begin
                if (sb.i_rvalid && !sb.i_rready) begin
                    stall_r      <= 1'b1;
                    stall_data_r <= sb.i_rdata;
                end else begin
                    stall_r <= 1'b0;
                end
            end
        end
    end

    // RUN/FAIL state machine with first-failure capture
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r        <= ST_RUN;
            fail_r         <= 1'b0;
            err_code_r     <= ERR_NONE;
            err_expected_r <= {WIDTH{1'b0}};
            err_actual_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (any_err_s) begin
                        state_r        <= ST_FAIL;
                        fail_r         <= 1'b1;
                        err_code_r     <= code_s;
                        err_expected_r <= mismatch_s ? expected_s : {WIDTH{1'b0}};
                        err_actual_r   <= sb.i_rdata;
                    end
                end
                ST_FAIL: begin
                    fail_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_FAIL;
                    fail_r  <= 1'b1;
                end
            endcase
        end
    end

    assign sb.o_nPushed     = n_pushed_r;
    assign sb.o_nPopped     = n_popped_r;
    assign sb.o_nErrors     = n_errors_r;
    assign sb.o_occupancy   = occ_r;
    assign sb.o_fail        = fail_r;
    assign sb.o_errCode     = err_code_r;
    assign sb.o_errExpected = err_expected_r;
    assign sb.o_errActual   = err_actual_r;

endmodule
